prog_mem_loader: RTL and testbench
==================================

# prog_mem_loader

Instruction-memory server for the 8-bit CPU core: accepts a program image as a valid/ready byte stream, writes it into a 256×8 instruction RAM, then serves instruction bytes to the CPU's fetch interface (`cmd_addr` in, `cmd_8bit` out). It is the responder end of the CPU fetch path. It holds the CPU in reset while the image is loading and releases it once the image is complete.

## Interface

Parameters:
- `ADDR_W`, 8: fetch/write address width; RAM depth is 2^ADDR_W.
- `DATA_W`, 8: instruction byte width.

Ports:
- `clk`  in  1  single clock; all logic on rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `load_start`  in  1  one-cycle request to begin a new image load.
- `load_len`  in  ADDR_W  image length in bytes; sampled with `load_start`; 0 means 256.
- `load_valid`  in  1  `load_data` holds a valid byte.
- `load_data`  in  DATA_W  image byte.
- `load_ready`  out  1  loader accepts a byte this cycle.
- `load_done`  out  1  one-cycle pulse after the last byte is written.
- `checksum`  out  DATA_W  mod-256 sum of the bytes accepted in the current or most recent load.
- `cpu_rst`  out  1  reset to the CPU; high whenever the state is not RUN.
- `cmd_addr`  in  ADDR_W  CPU fetch address.
- `cmd_8bit`  out  DATA_W  instruction byte returned to the CPU.

## Operation

- States: IDLE, LOAD, FLUSH, RUN.
- IDLE:
  - Entered on `rst`.
  - `cpu_rst`=1, `load_ready`=0, `cmd_8bit`=0.
  - `load_start` moves to LOAD.
- LOAD:
  - `load_ready`=1.
  - A byte is accepted when `load_valid` and `load_ready` are both high. It is written to RAM[`wr_ptr`], `wr_ptr` increments, and the byte is added to `checksum`, wrapping mod 256.
  - The transfer that writes byte `len`-1 moves to FLUSH. `len` is the `load_len` value latched at start.
  - `load_start` during LOAD is ignored.
- FLUSH:
  - Lasts exactly one cycle.
  - `load_done`=1, `cpu_rst`=1, `load_ready`=0.
  - Always moves to RUN.
- RUN:
  - `cpu_rst`=0.
  - `cmd_8bit` is the registered value of RAM[`cmd_addr`].
  - `load_start` moves to LOAD, which re-asserts `cpu_rst`. This reload path is how a new program is loaded into a running system.
- On `load_start` acceptance:
  - `wr_ptr` is cleared to 0.
  - `checksum` is cleared to 0.
  - `load_len` is latched.
- Width rules:
  - `wr_ptr` is ADDR_W bits.
  - A length of 0 means the load ends when `wr_ptr` wraps from 255, i.e. 256 bytes.
- Unwritten RAM locations keep prior contents. RAM is not cleared by `rst`.
- A `rst` mid-load returns to IDLE with `cpu_rst`=1. Partially written bytes remain in RAM. `checksum` is reset to 0.

## Timing

- Reset values:
  - state=IDLE.
  - `cpu_rst`=1, `load_ready`=0, `load_done`=0.
  - `checksum`=0, `cmd_8bit`=0, `wr_ptr`=0.
- If `load_start` is high at cycle N in IDLE or RUN:
  - LOAD begins at N+1, and `load_ready`=1 at N+1.
  - `cpu_rst`=1 from N+1 when coming from RUN.
- If the last byte is accepted at cycle M:
  - FLUSH at M+1: `load_done`=1 and `checksum` is final.
  - RUN at M+2: `cpu_rst`=0.
- Fetch latency is one cycle: `cmd_addr`=A at cycle K gives `cmd_8bit`=RAM[A] at K+1, in RUN only.
  - Outside RUN, `cmd_8bit` is forced to 0.
- Minimum load time is `len`+2 cycles from `load_start` to RUN, with back-to-back valid bytes.
- `load_valid` may drop at any time. No byte is lost and no state changes while it is low.
- If `rst` and `load_start` are high in the same cycle, `rst` wins.
- If `load_start` and `load_valid` are high in the same cycle in IDLE or RUN, the byte is not accepted, because `load_ready` is 0 that cycle.

## Structure

- Package `prog_loader_pkg` holds:
  - the state enum `loader_state_t` {IDLE, LOAD, FLUSH, RUN};
  - the constants `PL_ADDR_W`=8, `PL_DATA_W`=8, `PL_DEPTH`=256.
- Sub-module `prog_ram`:
  - 2^ADDR_W × DATA_W;
  - one synchronous write port;
  - one synchronous read port with registered output.
- The top level contains the FSM, `wr_ptr`, the length latch, the checksum, and the output gating of `cmd_8bit`.

## Test plan

- **Reset:** assert `rst` for 2 cycles.
  - Expect `cpu_rst`=1, `load_ready`=0, `cmd_8bit`=0x00, `checksum`=0x00.
- **Basic load/fetch:** `load_start` with `load_len`=4, then stream 0x10,0x21,0x32,0x43 back-to-back.
  - `load_done` pulses 1 cycle after the 4th byte; `checksum`=0xA6; `cpu_rst` falls the following cycle.
  - `cmd_addr`=2 gives `cmd_8bit`=0x32 one cycle later.
- **Gapped stream:** `load_len`=3, with `load_valid` toggling 1,0,0,1,0,1 carrying 0x01,0x02,0x03.
  - Exactly 3 writes occur and `checksum`=0x06.
  - `load_start` pulsed mid-load is ignored.
- **Full depth:** `load_len`=0 with 256 bytes of value i.
  - `load_done` comes only after byte 255, with `checksum`=0x80.
  - Fetch of `cmd_addr`=0xFF returns 0xFF, and `cmd_addr`=0x00 returns 0x00.
- **Reload from RUN:** in RUN, pulse `load_start` with `load_len`=1 and byte 0xAA.
  - `cpu_rst`=1 from the next cycle until RUN is re-entered.
  - Addr 0 returns 0xAA; addr 1 keeps its old value.
- **Reset mid-load:** assert `rst` after 2 of 5 bytes.
  - State is IDLE, `cpu_rst`=1, `checksum`=0.
  - A subsequent full load completes normally.

Source files
------------

// File: rtl/prog_loader_pkg.sv
// Shared types and sizing constants for the program-memory loader and its RAM.
package prog_loader_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        FLUSH = 2'd2,
        RUN   = 2'd3
    } loader_state_t;

    localparam int PL_ADDR_W = 8;
    localparam int PL_DATA_W = 8;
    localparam int PL_DEPTH  = 1 << PL_ADDR_W;

endpackage

// File: rtl/prog_ram.sv
// Instruction RAM: one synchronous write port, one read port with a registered output.
module prog_ram #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [1 << ADDR_W];

    // No reset: contents survive rst so a partial load leaves prior bytes intact.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/prog_mem_loader.sv
// Loads a program image from a byte stream into instruction RAM, holding the CPU in
// reset until the image is complete, then serves fetches from the RAM.
module prog_mem_loader
    import prog_loader_pkg::*;
#(
    parameter int ADDR_W = PL_ADDR_W,
    parameter int DATA_W = PL_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_start,
    input  logic [ADDR_W-1:0] load_len,
    input  logic              load_valid,
    input  logic [DATA_W-1:0] load_data,
    output logic              load_ready,
    output logic              load_done,
    output logic [DATA_W-1:0] checksum,
    output logic              cpu_rst,
    input  logic [ADDR_W-1:0] cmd_addr,
    output logic [DATA_W-1:0] cmd_8bit,
    output loader_state_t     state
);

    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] len_q;
    logic [ADDR_W-1:0] last_idx;
    logic              xfer;
    logic [DATA_W-1:0] ram_q;

    // Handshake: a byte transfers on a rising edge where load_valid && load_ready;
    // load_valid may drop at any time and nothing advances while it is low.
    assign xfer     = load_valid && load_ready;
    // A latched length of 0 gives last_idx 255, so the load ends as wr_ptr wraps.
    assign last_idx = len_q - ADDR_W'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cpu_rst    <= 1'b1;
            load_ready <= 1'b0;
            load_done  <= 1'b0;
            checksum   <= '0;
            wr_ptr     <= '0;
            len_q      <= '0;
        end else begin
            load_done <= 1'b0;
            case (state)
                IDLE, RUN: begin
                    if (load_start) begin
                        state      <= LOAD;
                        load_ready <= 1'b1;
                        cpu_rst    <= 1'b1;
                        wr_ptr     <= '0;
                        checksum   <= '0;
                        len_q      <= load_len;
                    end
                end
                LOAD: begin
                    if (xfer) begin
                        wr_ptr   <= wr_ptr + ADDR_W'(1);
                        checksum <= checksum + load_data;
                        if (wr_ptr == last_idx) begin
                            state      <= FLUSH;
                            load_ready <= 1'b0;
                            load_done  <= 1'b1;
                        end
                    end
                end
                FLUSH: begin
                    state   <= RUN;
                    cpu_rst <= 1'b0;
                end
                default: begin
                    state      <= IDLE;
                    cpu_rst    <= 1'b1;
                    load_ready <= 1'b0;
                end
            endcase
        end
    end

    prog_ram #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W)
    ) u_ram (
        .clk    (clk),
        .wr_en  (xfer),
        .wr_addr(wr_ptr),
        .wr_data(load_data),
        .rd_addr(cmd_addr),
        .rd_data(ram_q)
    );

    // The CPU must never see stale or half-loaded bytes outside RUN.
    assign cmd_8bit = (state == RUN) ? ram_q : '0;

endmodule

// File: tb/tb_prog_mem_loader.sv
// Directed bench for prog_mem_loader: load, gapped load, full depth, reload and reset-mid-load.
module tb_prog_mem_loader;
    import prog_loader_pkg::*;

    logic          clk;
    logic          rst;
    logic          load_start;
    logic [7:0]    load_len;
    logic          load_valid;
    logic [7:0]    load_data;
    logic          load_ready;
    logic          load_done;
    logic [7:0]    checksum;
    logic          cpu_rst;
    logic [7:0]    cmd_addr;
    logic [7:0]    cmd_8bit;
    loader_state_t dut_state;

    int checks = 0;
    int errors = 0;

    prog_mem_loader dut (
        .clk       (clk),
        .rst       (rst),
        .load_start(load_start),
        .load_len  (load_len),
        .load_valid(load_valid),
        .load_data (load_data),
        .load_ready(load_ready),
        .load_done (load_done),
        .checksum  (checksum),
        .cpu_rst   (cpu_rst),
        .cmd_addr  (cmd_addr),
        .cmd_8bit  (cmd_8bit),
        .state     (dut_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one rising edge and settle; outputs then show the post-edge values.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_load(input logic [7:0] len);
        load_start = 1'b1;
        load_len   = len;
        step();
        load_start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        load_valid = 1'b1;
        load_data  = b;
        step();
        load_valid = 1'b0;
    endtask

    task automatic fetch(input string tag, input logic [7:0] addr, input logic [7:0] exp);
        cmd_addr = addr;
        step();
        check(tag, 32'(cmd_8bit), 32'(exp));
    endtask

    initial begin
        rst        = 1'b0;
        load_start = 1'b0;
        load_len   = 8'd0;
        load_valid = 1'b0;
        load_data  = 8'd0;
        cmd_addr   = 8'd0;

        // Reset
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        check("rst_state", 32'(dut_state), 32'(IDLE));
        check("rst_cpu_rst", 32'(cpu_rst), 32'd1);
        check("rst_ready", 32'(load_ready), 32'd0);
        check("rst_done", 32'(load_done), 32'd0);
        check("rst_cmd", 32'(cmd_8bit), 32'h00);
        check("rst_csum", 32'(checksum), 32'h00);

        // Basic load/fetch
        start_load(8'd4);
        check("basic_ready", 32'(load_ready), 32'd1);
        check("basic_state", 32'(dut_state), 32'(LOAD));
        send_byte(8'h10);
        send_byte(8'h21);
        send_byte(8'h32);
        check("basic_no_done_early", 32'(load_done), 32'd0);
        send_byte(8'h43);
        check("basic_done", 32'(load_done), 32'd1);
        check("basic_csum", 32'(checksum), 32'hA6);
        check("basic_flush_cpu_rst", 32'(cpu_rst), 32'd1);
        check("basic_flush_ready", 32'(load_ready), 32'd0);
        step();
        check("basic_done_pulse", 32'(load_done), 32'd0);
        check("basic_run_cpu_rst", 32'(cpu_rst), 32'd0);
        check("basic_run_state", 32'(dut_state), 32'(RUN));
        fetch("basic_fetch2", 8'd2, 8'h32);
        fetch("basic_fetch0", 8'd0, 8'h10);

        // Gapped stream, with an ignored mid-load start
        start_load(8'd3);
        check("gap_cpu_rst", 32'(cpu_rst), 32'd1);
        check("gap_csum_clear", 32'(checksum), 32'h00);
        check("gap_cmd_gated", 32'(cmd_8bit), 32'h00);
        send_byte(8'h01);
        step();
        load_start = 1'b1;
        load_len   = 8'd9;
        step();
        load_start = 1'b0;
        check("gap_hold_csum", 32'(checksum), 32'h01);
        check("gap_hold_state", 32'(dut_state), 32'(LOAD));
        send_byte(8'h02);
        step();
        send_byte(8'h03);
        check("gap_done", 32'(load_done), 32'd1);
        check("gap_csum", 32'(checksum), 32'h06);
        step();
        fetch("gap_fetch0", 8'd0, 8'h01);
        fetch("gap_fetch1", 8'd1, 8'h02);
        fetch("gap_fetch2", 8'd2, 8'h03);
        fetch("gap_fetch3_kept", 8'd3, 8'h43);

        // Full depth: length 0 means 256 bytes
        start_load(8'd0);
        for (int i = 0; i < 256; i++) begin
            send_byte(8'(i));
            if (i == 254) begin
                check("full_no_done_254", 32'(load_done), 32'd0);
                check("full_state_254", 32'(dut_state), 32'(LOAD));
            end
        end
        check("full_done", 32'(load_done), 32'd1);
        check("full_csum", 32'(checksum), 32'h80);
        step();
        fetch("full_fetch_ff", 8'hFF, 8'hFF);
        fetch("full_fetch_00", 8'h00, 8'h00);
        fetch("full_fetch_80", 8'h80, 8'h80);

        // Reload from RUN; the byte offered alongside load_start is not accepted
        load_start = 1'b1;
        load_len   = 8'd1;
        load_valid = 1'b1;
        load_data  = 8'h55;
        step();
        load_start = 1'b0;
        load_valid = 1'b0;
        check("reload_cpu_rst", 32'(cpu_rst), 32'd1);
        check("reload_state", 32'(dut_state), 32'(LOAD));
        check("reload_no_accept", 32'(checksum), 32'h00);
        send_byte(8'hAA);
        check("reload_flush_cpu_rst", 32'(cpu_rst), 32'd1);
        check("reload_done", 32'(load_done), 32'd1);
        check("reload_csum", 32'(checksum), 32'hAA);
        step();
        check("reload_run_cpu_rst", 32'(cpu_rst), 32'd0);
        fetch("reload_fetch0", 8'd0, 8'hAA);
        fetch("reload_fetch1", 8'd1, 8'h01);

        // Reset mid-load, with load_start colliding with rst
        start_load(8'd5);
        send_byte(8'h11);
        send_byte(8'h22);
        rst        = 1'b1;
        load_start = 1'b1;
        step();
        step();
        rst        = 1'b0;
        load_start = 1'b0;
        check("midrst_state", 32'(dut_state), 32'(IDLE));
        check("midrst_cpu_rst", 32'(cpu_rst), 32'd1);
        check("midrst_csum", 32'(checksum), 32'h00);
        check("midrst_ready", 32'(load_ready), 32'd0);
        check("midrst_cmd", 32'(cmd_8bit), 32'h00);
        step();
        check("midrst_stays_idle", 32'(dut_state), 32'(IDLE));

        start_load(8'd2);
        send_byte(8'h5A);
        send_byte(8'hA5);
        check("after_done", 32'(load_done), 32'd1);
        check("after_csum", 32'(checksum), 32'hFF);
        step();
        check("after_run_cpu_rst", 32'(cpu_rst), 32'd0);
        fetch("after_fetch0", 8'd0, 8'h5A);
        fetch("after_fetch1", 8'd1, 8'hA5);
        fetch("after_fetch2_kept", 8'd2, 8'h02);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
